// File: rtl/cpu16_pkg.sv
// ---------------------------------------------------------------------------
// cpu16_pkg
// Shared definitions for the 16-bit processor front end.
//   INSTR_W      : instruction / PC width in bits
//   NOP_WORD     : instruction value presented to decode when nothing is held
//   OPCODE_MSB/LSB : opcode field bounds inside an instruction word
//   ifid_state_t : IF/ID buffer occupancy state; the encoding equals the
//                  number of held words so the count can be cast directly
//   opcode_of()  : extracts the opcode field from an instruction word
// ---------------------------------------------------------------------------
package cpu16_pkg;

    localparam int              INSTR_W    = 16;
    localparam logic [15:0]     NOP_WORD   = 16'h0000;
    localparam int              OPCODE_MSB = 15;
    localparam int              OPCODE_LSB = 12;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } ifid_state_t;

    function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(
        input logic [INSTR_W-1:0] instr
    );
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/if_id_slot.sv
// ---------------------------------------------------------------------------
// if_id_slot
// One storage slot of the IF/ID buffer: an enable-loaded register pair
// holding an instruction and its PC+4 value.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, clears both registers to 0
//   load    : capture d_instr / d_pc4 on the next rising edge
//   d_instr : instruction to capture
//   d_pc4   : PC+4 to capture
//   q_instr : held instruction
//   q_pc4   : held PC+4
// ---------------------------------------------------------------------------
module if_id_slot #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] d_instr,
    input  logic [W-1:0] d_pc4,
    output logic [W-1:0] q_instr,
    output logic [W-1:0] q_pc4
);

    logic [W-1:0] instr_q;
    logic [W-1:0] instr_d;
    logic [W-1:0] pc4_q;
    logic [W-1:0] pc4_d;

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        if (load) begin
            instr_d = d_instr;
            pc4_d   = d_pc4;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr_q <= '0;
            pc4_q   <= '0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    assign q_instr = instr_q;
    assign q_pc4   = pc4_q;

endmodule

// File: rtl/if_id_buffer.sv
// ---------------------------------------------------------------------------
// if_id_buffer
// Two-entry elastic buffer between instruction fetch and decode. Each
// accepted word (instruction + PC+4) is shown to decode one cycle after it
// is pushed. One cycle of decode back-pressure is absorbed in the tail
// slot. A branch flush discards all held words and any word offered in the
// same cycle.
// Ports:
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   in_valid       : fetch offers a word
//   in_instr/in_pc4: offered instruction and its PC+4
//   in_ready       : buffer can accept a word (registered state only)
//   flush          : branch taken; empty the buffer, drop the offered word
//   out_valid      : head word valid for decode
//   out_instr      : head instruction, NOP_WORD when empty
//   out_pc4        : head PC+4, 0 when empty
//   out_ready      : decode consumes the head
//   stall_cnt      : saturating count of cycles with out_valid && !out_ready
// ---------------------------------------------------------------------------
module if_id_buffer
    import cpu16_pkg::*;
#(
    parameter int                         INSTR_W  = cpu16_pkg::INSTR_W,
    parameter logic [cpu16_pkg::INSTR_W-1:0] NOP_WORD = cpu16_pkg::NOP_WORD,
    parameter int                         CNT_W    = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [INSTR_W-1:0] in_pc4,
    output logic               in_ready,
    input  logic               flush,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [INSTR_W-1:0] out_pc4,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic [1:0]         count_q;
    logic [1:0]         count_d;
    logic [CNT_W-1:0]   stall_q;
    logic [CNT_W-1:0]   stall_d;
    ifid_state_t        state;

    logic               push;
    logic               pop;
    logic               head_load;
    logic               tail_load;
    logic               head_from_tail;

    logic [INSTR_W-1:0] head_d_instr;
    logic [INSTR_W-1:0] head_d_pc4;
    logic [INSTR_W-1:0] head_instr;
    logic [INSTR_W-1:0] head_pc4;
    logic [INSTR_W-1:0] tail_instr;
    logic [INSTR_W-1:0] tail_pc4;

    // The state encoding is the occupancy count itself.
    assign state     = ifid_state_t'(count_q);

    // Handshake flags come only from registered occupancy, so out_ready has
    // no combinational route to in_ready.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);

    assign push = in_valid  && in_ready  && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        count_d        = count_q;
        head_load      = 1'b0;
        tail_load      = 1'b0;
        head_from_tail = 1'b0;
        if (flush) begin
            // Slot contents are left stale; the empty state masks them.
            count_d = 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head_load = 1'b1;
                        count_d   = 2'd1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        // Head is consumed and replaced by the new word.
                        head_load = 1'b1;
                    end else if (push) begin
                        tail_load = 1'b1;
                        count_d   = 2'd2;
                    end else if (pop) begin
                        count_d   = 2'd0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_load      = 1'b1;
                        head_from_tail = 1'b1;
                        count_d        = 2'd1;
                    end
                end
                default: begin
                    count_d = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        head_d_instr = in_instr;
        head_d_pc4   = in_pc4;
        if (head_from_tail) begin
            head_d_instr = tail_instr;
            head_d_pc4   = tail_pc4;
        end
    end

    // Counts every cycle decode is shown a word but does not take it,
    // including flush cycles; only reset clears it.
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 2'd0;
            stall_q <= '0;
        end else begin
            count_q <= count_d;
            stall_q <= stall_d;
        end
    end

    if_id_slot #(.W(INSTR_W)) u_head (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (head_load),
        .d_instr (head_d_instr),
        .d_pc4   (head_d_pc4),
        .q_instr (head_instr),
        .q_pc4   (head_pc4)
    );

    if_id_slot #(.W(INSTR_W)) u_tail (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (tail_load),
        .d_instr (in_instr),
        .d_pc4   (in_pc4),
        .q_instr (tail_instr),
        .q_pc4   (tail_pc4)
    );

    assign out_instr = out_valid ? head_instr : NOP_WORD;
    assign out_pc4   = out_valid ? head_pc4   : '0;
    assign stall_cnt = stall_q;

endmodule
